// File: rtl/sel_dist_pkg.sv
// Shared constants and types for the 1-to-4 stream distributor.
// Lane indices and mode encodings live here so the top and the bench agree on them.
package sel_dist_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    typedef logic [SEL_W-1:0] lane_idx_t;

    // Round-robin successor; the 2-bit width makes 3 -> 0 wrap for free.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return lane_idx_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/sel_1_4_dist_if.sv
// Producer/consumer bundle of the distributor: one input stream, four output lanes, status.
// The master side drives the producer inputs and lane readies; the slave side is the distributor.
interface sel_1_4_dist_if #(
    parameter int W = 8
);
    import sel_dist_pkg::*;

    logic                  mode;
    logic [W-1:0]          in_data;
    lane_idx_t             in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*W-1:0]     out_data;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;
    lane_idx_t             rr_ptr;
    logic                  busy;

    modport master (
        output mode, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, busy
    );

    modport slave (
        input  mode, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, busy
    );

endinterface

// File: rtl/sel_dist_slot.sv
// One-entry register slice for a single output lane.
// A load wins over a drain in the same cycle, which gives one word per cycle through the lane.
module sel_dist_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] q,
    output logic         free
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            // NOTE: the data register is reset too, because the lane must read zero after reset.
            q     <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                q     <= d;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign free = ~valid | ready;

endmodule

// File: rtl/sel_1_4_dist.sv
// 1-to-4 stream distributor: routes each accepted word to one lane chosen by IN_SEL or a
// round-robin pointer. Each lane is a one-entry slot with its own valid/ready handshake.
module sel_1_4_dist
    import sel_dist_pkg::*;
#(
    parameter int W = 8
) (
    input logic           clk,
    input logic           rst,
    sel_1_4_dist_if.slave bus
);

    lane_idx_t        rr_ptr_q;
    lane_idx_t        tgt;
    logic             acc;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  free;
    logic [N_CH-1:0]  valid;
    logic [W-1:0]     q [N_CH];

    assign tgt         = (bus.mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
    // Readiness looks only at the target lane; a full lane elsewhere never blocks.
    assign bus.in_ready = ~rst & free[tgt];
    assign acc         = bus.in_valid & bus.in_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load = '0;
        if (acc) begin
            load[tgt] = 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        sel_dist_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[i]),
            .d     (bus.in_data),
            .valid (valid[i]),
            .ready (bus.out_ready[i]),
            .q     (q[i]),
            .free  (free[i])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.out_data[i*W +: W] = q[i];
        end
    end

    // Strict order: the pointer moves only on a round-robin accept, never on stall or mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (acc && (bus.mode == MODE_RR)) begin
            rr_ptr_q <= next_lane(rr_ptr_q);
        end
    end

    assign bus.out_valid = valid;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.busy      = |valid;

    a_one_load : assert property (@(posedge clk) $onehot0(load));
    a_rst_ready : assert property (@(posedge clk) rst |-> !bus.in_ready);

endmodule

// File: tb/tb_sel_1_4_dist.sv
// Directed bench for sel_1_4_dist: a lane-array model plus per-lane word queues checked every
// cycle, with hand-computed literal expectations at the key points of each scenario.
module tb_sel_1_4_dist;
    import sel_dist_pkg::*;

    logic clk;
    logic rst;

    sel_1_4_dist_if #(.W(8)) bus ();

    sel_1_4_dist #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: lane contents as arrays, and a queue of words owed to each lane's consumer.
    logic [3:0] mv;
    logic [7:0] md [4];
    logic [1:0] mptr;
    logic       model_ok = 1'b0;
    logic [7:0] owed [4][$];

    always @(posedge clk) begin
        logic [1:0] t;
        logic       a;
        logic [3:0] nv;
        logic [7:0] w;
        if (rst) begin
            mv       <= '0;
            mptr     <= '0;
            model_ok <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                md[i] <= '0;
                owed[i].delete();
            end
        end else if (model_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (owed[i].size() == 0) begin
                        check("drain_unowed", {31'd0, bus.out_valid[i]}, 32'd0);
                    end else begin
                        w = owed[i].pop_front();
                        check("drain_word", {24'd0, bus.out_data[i*8 +: 8]}, {24'd0, w});
                    end
                end
            end
            t  = bus.mode ? mptr : bus.in_sel;
            a  = bus.in_valid && (!mv[t] || bus.out_ready[t]);
            nv = mv & ~bus.out_ready;
            if (a) begin
                nv[t] = 1'b1;
                md[t] <= bus.in_data;
                owed[t].push_back(bus.in_data);
                if (bus.mode) mptr <= mptr + 2'd1;
            end
            mv <= nv;
        end
    end

    always @(negedge clk) begin
        logic [1:0] t;
        if (model_ok) begin
            t = bus.mode ? mptr : bus.in_sel;
            check("m_in_ready", {31'd0, bus.in_ready}, {31'd0, !rst && (!mv[t] || bus.out_ready[t])});
            check("m_out_valid", {28'd0, bus.out_valid}, {28'd0, mv});
            check("m_out_data", bus.out_data, {md[3], md[2], md[1], md[0]});
            check("m_rr_ptr", {30'd0, bus.rr_ptr}, {30'd0, mptr});
            check("m_busy", {31'd0, bus.busy}, {31'd0, |mv});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    function automatic logic [7:0] lane(input int i);
        return bus.out_data[i*8 +: 8];
    endfunction

    initial begin
        rst           = 1'b1;
        bus.mode      = MODE_DIRECTED;
        bus.in_data   = 8'h55;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b0000;

        // Reset held two cycles with a word offered.
        step();
        neg();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        neg();
        check("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        check("rst_rr_ptr", {30'd0, bus.rr_ptr}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        step();

        // Directed routing to all four lanes, no consumer ready.
        for (int k = 0; k < 4; k++) begin
            bus.in_data  = 8'(8'h11 * (k + 1));
            bus.in_sel   = 2'(k);
            bus.in_valid = 1'b1;
            neg();
            check("dir_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
        end
        bus.in_data = 8'h99;
        bus.in_sel  = 2'd2;
        neg();
        check("dir_all_valid", {28'd0, bus.out_valid}, 32'hF);
        check("dir_lanes", bus.out_data, 32'h44332211);
        check("dir_full_stall", {31'd0, bus.in_ready}, 32'd0);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;

        // Full throughput into lane 1, then backpressure.
        bus.in_sel    = 2'd1;
        bus.out_ready = 4'b0010;
        for (int v = 1; v <= 8; v++) begin
            bus.in_data  = 8'(v);
            bus.in_valid = 1'b1;
            neg();
            check("thr_in_ready", {31'd0, bus.in_ready}, 32'd1);
            if (v > 1) check("thr_lane1", {24'd0, lane(1)}, 32'(v - 1));
            step();
        end
        bus.in_data   = 8'h09;
        bus.out_ready = 4'b0000;
        for (int s = 0; s < 3; s++) begin
            neg();
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_frozen", {24'd0, lane(1)}, 32'h08);
            step();
        end
        bus.out_ready = 4'b0010;
        neg();
        check("bp_resume", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        neg();
        check("bp_last", {24'd0, lane(1)}, 32'h09);
        step();
        bus.out_ready = 4'b0000;

        // Round-robin wrap with lane 2 not ready, then stall on lane 2.
        bus.mode      = MODE_RR;
        bus.out_ready = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            bus.in_data  = 8'(8'hA0 + k);
            bus.in_valid = 1'b1;
            neg();
            check("rr_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
        end
        bus.in_data = 8'hB0;
        neg();
        check("rr_ptr_wrap", {30'd0, bus.rr_ptr}, 32'd2);
        check("rr_stall", {31'd0, bus.in_ready}, 32'd0);
        check("rr_valid", {28'd0, bus.out_valid}, 32'h6);
        check("rr_lane2", {24'd0, lane(2)}, 32'hA2);
        step();
        neg();
        check("rr_stall2", {31'd0, bus.in_ready}, 32'd0);
        check("rr_valid2", {28'd0, bus.out_valid}, 32'h4);
        check("rr_ptr_hold", {30'd0, bus.rr_ptr}, 32'd2);
        step();
        bus.out_ready = 4'b1111;
        neg();
        check("rr_unstall", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        neg();
        check("rr_lane2_new", {24'd0, lane(2)}, 32'hB0);
        check("rr_ptr3", {30'd0, bus.rr_ptr}, 32'd3);
        step();

        // Mode switch keeps the pointer.
        bus.mode     = MODE_DIRECTED;
        bus.in_sel   = 2'd0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC0;
        step();
        bus.in_data = 8'hC1;
        step();
        bus.in_valid = 1'b0;
        neg();
        check("ms_ptr_kept", {30'd0, bus.rr_ptr}, 32'd3);
        check("ms_lane0", {24'd0, lane(0)}, 32'hC1);
        bus.mode     = MODE_RR;
        bus.in_data  = 8'hD0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        neg();
        check("ms_rr_lane3_valid", {28'd0, bus.out_valid}, 32'h8);
        check("ms_rr_lane3", {24'd0, lane(3)}, 32'hD0);
        check("ms_ptr_wrap", {30'd0, bus.rr_ptr}, 32'd0);
        step();

        // Mid-operation reset with lanes 0 and 2 full.
        bus.mode      = MODE_DIRECTED;
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'hE0;
        step();
        bus.in_sel  = 2'd2;
        bus.in_data = 8'hE2;
        step();
        bus.in_valid = 1'b0;
        neg();
        check("mr_full", {28'd0, bus.out_valid}, 32'h5);
        step();
        rst = 1'b1;
        neg();
        check("mr_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        rst          = 1'b0;
        bus.mode     = MODE_RR;
        bus.in_data  = 8'hF0;
        bus.in_valid = 1'b1;
        neg();
        check("mr_cleared", {28'd0, bus.out_valid}, 32'd0);
        check("mr_ptr", {30'd0, bus.rr_ptr}, 32'd0);
        check("mr_data", bus.out_data, 32'd0);
        check("mr_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        neg();
        check("mr_first_valid", {28'd0, bus.out_valid}, 32'h1);
        check("mr_first_data", {24'd0, lane(0)}, 32'hF0);
        check("mr_first_ptr", {30'd0, bus.rr_ptr}, 32'd1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
